online_operand_serializer: RTL and testbench
============================================

// Module: online_operand_serializer
// PURPOSE
//  Synthesizable successor to the file-driven digit feed used by On_line_divider benches.
//  Buffers parallel borrow-save operand pairs (dividend x, divisor d) in a small FIFO.
//  Emits them MSD-first as radix-2 signed-digit pairs, one pair per divider read request.
//  After PREC digits, appends ONLINE_DELAY zero digits to flush the divider's online delay.
//  Sits between a host/bus producer and On_line_divider (digit_req <= read_indicator).
// PARAMETERS
//  PREC          8  digits per operand (also width of each plus/minus vector)
//  DEPTH         4  operand-pair FIFO entries (>=2)
//  ONLINE_DELAY  3  zero-digit flush pairs appended per operation (>=1)
// PORTS
//  clk          in   1              rising-edge clock
//  reset        in   1              synchronous, active-high reset
//  in_valid     in   1              producer offers operand pair
//  in_ready     out  1              FIFO not full; push when in_valid&in_ready
//  in_x_plus    in   PREC           dividend positive bits, bit PREC-1 = MSD
//  in_x_minus   in   PREC           dividend negative bits
//  in_d_plus    in   PREC           divisor positive bits
//  in_d_minus   in   PREC           divisor negative bits
//  digit_req    in   1              divider requests next digit pair
//  x_digit      out  2              {plus,minus}: 10=+1, 01=-1, 00=0
//  d_digit      out  2              same encoding
//  digit_valid  out  1              x_digit/d_digit valid this cycle
//  op_start     out  1              with first digit of an operation
//  op_last      out  1              with last flush digit of an operation
//  busy         out  1              state != IDLE
//  underrun     out  1              sticky: request with nothing to send
//  illegal_digit out 1              sticky: 11 code pushed (see CONFIGURATION)
//  fifo_count   out  $clog2(DEPTH+1) entries held in FIFO (excludes active op)
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1; FIFO empty; state IDLE; flags cleared.
//  Latency: digit_req sampled at posedge t -> digit pair registered, valid in cycle t+1.
//    No req -> digit_valid=0, digits=00, op_start=op_last=0.
//  FSM IDLE/SHIFT/FLUSH; digit counter cnt.
//  IDLE + req + FIFO non-empty: pop head, emit MSD pair with op_start=1, load rest -> SHIFT.
//  IDLE + req + FIFO empty: underrun<=1, nothing emitted, stay IDLE.
//  SHIFT + req: emit next digit; after digit PREC-1 -> FLUSH.
//    PREC=1: IDLE goes straight to FLUSH.
//  FLUSH + req: emit 00/00; on ONLINE_DELAY-th emit, op_last=1 -> IDLE.
//  Next req pops the following op with no bubble.
//  FIFO: in_ready = count<DEPTH, combinational from registered count.
//    Push and pop in same cycle: count unchanged; legal at full (pop frees slot, push still
//    blocked by in_ready=0) and at empty (push stored, pop not possible).
//  Pointers wrap modulo DEPTH. fifo_count saturates at DEPTH by construction.
//  Reset mid-operation: active op and FIFO contents discarded, no partial op_last.
//  Digit code 11 from the shift path is never reinterpreted; handled only per macro below.
// CONFIGURATION
//  ONLINE_SER_DIGIT_CHECK_EN defined:
//    On push, any bit position with plus=minus=1 is stored as 00.
//    illegal_digit<=1 (sticky until reset).
//  Undefined: operands stored verbatim; illegal_digit tied 0.
// STRUCTURE
//  Package online_div_pkg: DIG_ZERO/DIG_POS/DIG_NEG 2-bit constants.
//    Also the serializer state encoding (IDLE=0, SHIFT=1, FLUSH=2).
//  Sub-module online_sd_fifo: DEPTH x (4*PREC) sync FIFO, push/pop/count.
//  Top holds FSM, shift registers, counters, flags.
// TESTING (PREC=4, DEPTH=2, ONLINE_DELAY=2)
//  Reset 3 cycles -> all outputs 0, in_ready=1, fifo_count=0.
//  Push x+=1010 x-=0001 d+=1100 d-=0000, digit_req held 1 -> on 6 consecutive cycles:
//    x=10,00,10,01,00,00; d=10,10,00,00,00,00; op_start cycle1, op_last cycle6.
//  Push 3 ops, no req -> third blocked: in_ready=0, fifo_count=2.
//    One req -> count=1, in_ready=1 next cycle.
//  digit_req on alternate cycles -> digit_valid only the cycle after each req.
//    Digit order as above.
//  req with FIFO empty and IDLE -> underrun=1 stays set, digit_valid=0.
//  reset after 2 digits emitted -> next cycle busy=0, fifo_count=0, digits 00.
//  Macro on: push x+=1111 x-=1000 -> first x_digit=00, illegal_digit=1.

Source files
------------

// File: rtl/online_div_pkg.sv
// Shared constants for the online divider digit feed: signed-digit codes and
// the serializer state encoding.
package online_div_pkg;

  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } ser_state_t;

endpackage

// File: rtl/online_sd_fifo.sv
// Synchronous FIFO holding packed borrow-save operand pairs; registered count,
// pointers wrap modulo DEPTH. Storage is not reset, only pointers and count.
module online_sd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/online_operand_serializer.sv
// Serializes buffered borrow-save operand pairs MSD-first as radix-2 signed digits,
// then appends ONLINE_DELAY zero pairs. Macro ONLINE_SER_DIGIT_CHECK_EN enables 11-code scrubbing.
module online_operand_serializer
  import online_div_pkg::*;
#(
  parameter int PREC         = 8,
  parameter int DEPTH        = 4,
  parameter int ONLINE_DELAY = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PREC-1:0]            in_x_plus,
  input  logic [PREC-1:0]            in_x_minus,
  input  logic [PREC-1:0]            in_d_plus,
  input  logic [PREC-1:0]            in_d_minus,
  input  logic                       digit_req,
  output logic [1:0]                 x_digit,
  output logic [1:0]                 d_digit,
  output logic                       digit_valid,
  output logic                       op_start,
  output logic                       op_last,
  output logic                       busy,
  output logic                       underrun,
  output logic                       illegal_digit,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int W     = 4 * PREC;
  localparam int CNT_W = $clog2(PREC + ONLINE_DELAY + 1);

  ser_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [PREC-1:0]  xp_q, xm_q, dp_q, dm_q;
  logic [PREC-1:0]  xp_n, xm_n, dp_n, dm_n;
  logic [PREC-1:0]  hxp, hxm, hdp, hdm;
  logic [W-1:0]     push_data;
  logic [W-1:0]     head_data;
  logic             push, pop, fifo_empty, fifo_full;
  logic [1:0]       x_digit_p1, d_digit_p1, x_digit_n, d_digit_n;
  logic             vld_p1, vld_n;
  logic             start_p1, start_n, last_p1, last_n;
  logic             underrun_q, underrun_n;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

`ifdef ONLINE_SER_DIGIT_CHECK_EN
  logic illegal_q;
  logic bad_code;

  // A 11 position has no signed-digit meaning; it is scrubbed to 0 before storage.
  assign bad_code  = (|(in_x_plus & in_x_minus)) | (|(in_d_plus & in_d_minus));
  assign push_data = {in_x_plus & ~in_x_minus, in_x_minus & ~in_x_plus,
                      in_d_plus & ~in_d_minus, in_d_minus & ~in_d_plus};
  assign illegal_digit = illegal_q;

  always_ff @(posedge clk) begin
    if (reset)                illegal_q <= 1'b0;
    else if (push && bad_code) illegal_q <= 1'b1;
  end
`else
  assign push_data     = {in_x_plus, in_x_minus, in_d_plus, in_d_minus};
  assign illegal_digit = 1'b0;
`endif

  online_sd_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign {hxp, hxm, hdp, hdm} = head_data;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    xp_n       = xp_q;
    xm_n       = xm_q;
    dp_n       = dp_q;
    dm_n       = dm_q;
    pop        = 1'b0;
    vld_n      = 1'b0;
    x_digit_n  = DIG_ZERO;
    d_digit_n  = DIG_ZERO;
    start_n    = 1'b0;
    last_n     = 1'b0;
    underrun_n = underrun_q;
    if (digit_req) begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            vld_n     = 1'b1;
            start_n   = 1'b1;
            x_digit_n = {hxp[PREC-1], hxm[PREC-1]};
            d_digit_n = {hdp[PREC-1], hdm[PREC-1]};
            xp_n      = hxp << 1;
            xm_n      = hxm << 1;
            dp_n      = hdp << 1;
            dm_n      = hdm << 1;
            state_n   = (PREC == 1) ? FLUSH : SHIFT;
            cnt_n     = (PREC == 1) ? CNT_W'(0) : CNT_W'(1);
          end else begin
            underrun_n = 1'b1;
          end
        end
        SHIFT: begin
          vld_n     = 1'b1;
          x_digit_n = {xp_q[PREC-1], xm_q[PREC-1]};
          d_digit_n = {dp_q[PREC-1], dm_q[PREC-1]};
          xp_n      = xp_q << 1;
          xm_n      = xm_q << 1;
          dp_n      = dp_q << 1;
          dm_n      = dm_q << 1;
          if (cnt == CNT_W'(PREC-1)) begin
            state_n = FLUSH;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        FLUSH: begin
          vld_n = 1'b1;
          if (cnt == CNT_W'(ONLINE_DELAY-1)) begin
            last_n  = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Output stage: digit pair registered one cycle after the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      vld_p1     <= 1'b0;
      x_digit_p1 <= DIG_ZERO;
      d_digit_p1 <= DIG_ZERO;
      start_p1   <= 1'b0;
      last_p1    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      vld_p1     <= vld_n;
      x_digit_p1 <= x_digit_n;
      d_digit_p1 <= d_digit_n;
      start_p1   <= start_n;
      last_p1    <= last_n;
      underrun_q <= underrun_n;
    end
  end

  always_ff @(posedge clk) begin
    xp_q <= xp_n;
    xm_q <= xm_n;
    dp_q <= dp_n;
    dm_q <= dm_n;
  end

  assign x_digit     = x_digit_p1;
  assign d_digit     = d_digit_p1;
  assign digit_valid = vld_p1;
  assign op_start    = start_p1;
  assign op_last     = last_p1;
  assign busy        = (state != IDLE);
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_online_operand_serializer.sv
// Bench for online_operand_serializer (PREC=4, DEPTH=2, ONLINE_DELAY=2): digit table plus
// behavioural scoreboard; honours ONLINE_SER_DIGIT_CHECK_EN.
module tb_online_operand_serializer;
  localparam int PREC = 4;
  localparam int DEPTH = 2;
  localparam int OD = 2;
  localparam int NDIG = PREC + OD;

  typedef struct packed {
    logic [PREC-1:0] xp, xm, dp, dm;
  } op_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] x, d;
    logic       st, last;
    logic [1:0] cnt;
    logic       busy, und, ill;
  } exp_t;

  typedef struct packed {
    op_t              op;
    logic [2*NDIG-1:0] ex;
    logic [2*NDIG-1:0] ed;
  } vec_t;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, digit_req;
  logic [PREC-1:0] in_x_plus, in_x_minus, in_d_plus, in_d_minus;
  logic [1:0] x_digit, d_digit;
  logic digit_valid, op_start, op_last, busy, underrun, illegal_digit;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;

  int total = 0;
  int bad = 0;

  op_t  mq[$];
  exp_t sbq[$];
  op_t  m_op;
  int   m_idx;
  logic m_busy, m_und, m_ill;

  online_operand_serializer #(.PREC(PREC), .DEPTH(DEPTH), .ONLINE_DELAY(OD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x_plus(in_x_plus), .in_x_minus(in_x_minus), .in_d_plus(in_d_plus),
    .in_d_minus(in_d_minus), .digit_req(digit_req), .x_digit(x_digit),
    .d_digit(d_digit), .digit_valid(digit_valid), .op_start(op_start),
    .op_last(op_last), .busy(busy), .underrun(underrun),
    .illegal_digit(illegal_digit), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic [PREC-1:0] xp, xm, dp, dm);
    op_t o;
    o.xp = xp; o.xm = xm; o.dp = dp; o.dm = dm;
    return o;
  endfunction

  function automatic op_t stored(input op_t o);
    op_t s = o;
`ifdef ONLINE_SER_DIGIT_CHECK_EN
    s.xp = o.xp & ~o.xm; s.xm = o.xm & ~o.xp;
    s.dp = o.dp & ~o.dm; s.dm = o.dm & ~o.dp;
`endif
    return s;
  endfunction

  task automatic model_clear();
    mq.delete();
    sbq.delete();
    m_busy = 1'b0; m_und = 1'b0; m_ill = 1'b0; m_idx = 0;
  endtask

  // One clock: drive inputs, predict the registered outputs, compare after the edge.
  task automatic step(input logic v, input op_t op, input logic req);
    exp_t e;
    logic acc;
    in_valid = v;
    {in_x_plus, in_x_minus, in_d_plus, in_d_minus} = op;
    digit_req = req;
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    acc = v && (mq.size() < DEPTH);
    e = '0;
    if (req) begin
      if (!m_busy) begin
        if (mq.size() > 0) begin
          m_op = mq.pop_front(); m_idx = 0; m_busy = 1'b1;
        end else begin
          m_und = 1'b1;
        end
      end
      if (m_busy) begin
        e.vld = 1'b1;
        if (m_idx < PREC) begin
          e.x = {m_op.xp[PREC-1-m_idx], m_op.xm[PREC-1-m_idx]};
          e.d = {m_op.dp[PREC-1-m_idx], m_op.dm[PREC-1-m_idx]};
        end
        e.st = (m_idx == 0);
        e.last = (m_idx == NDIG-1);
        if (e.last) m_busy = 1'b0;
        m_idx++;
      end
    end
    if (acc) begin
      mq.push_back(stored(op));
`ifdef ONLINE_SER_DIGIT_CHECK_EN
      if (((op.xp & op.xm) != 0) || ((op.dp & op.dm) != 0)) m_ill = 1'b1;
`endif
    end
    e.cnt = 2'(mq.size());
    e.busy = m_busy; e.und = m_und; e.ill = m_ill;
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk("digit_valid", 32'(digit_valid), 32'(e.vld));
    chk("x_digit", 32'(x_digit), 32'(e.x));
    chk("d_digit", 32'(d_digit), 32'(e.d));
    chk("op_start", 32'(op_start), 32'(e.st));
    chk("op_last", 32'(op_last), 32'(e.last));
    chk("fifo_count", 32'(fifo_count), 32'(e.cnt));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("underrun", 32'(underrun), 32'(e.und));
    chk("illegal_digit", 32'(illegal_digit), 32'(e.ill));
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; digit_req = 1'b0;
    {in_x_plus, in_x_minus, in_d_plus, in_d_minus} = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  vec_t tbl[3];
  op_t  nop;
  op_t  o;

  initial begin
    nop = '0;
    tbl[0] = '{op: mk(4'b1010, 4'b0001, 4'b1100, 4'b0000),
               ex: 12'b10_00_10_01_00_00, ed: 12'b10_10_00_00_00_00};
    tbl[1] = '{op: mk(4'b0101, 4'b1010, 4'b0011, 4'b0100),
               ex: 12'b01_10_01_10_00_00, ed: 12'b00_01_10_10_00_00};
    tbl[2] = '{op: mk(4'b1000, 4'b0000, 4'b0001, 4'b1110),
               ex: 12'b10_00_00_00_00_00, ed: 12'b01_01_01_10_00_00};

    do_reset();
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst fifo_count", 32'(fifo_count), 32'd0);
    chk("rst outputs", 32'({x_digit, d_digit, digit_valid, op_start, op_last,
                            busy, underrun, illegal_digit}), 32'd0);

    // Table: push each vector, then hold digit_req for the full digit sequence.
    for (int v = 0; v < 3; v++) begin
      step(1'b1, tbl[v].op, 1'b0);
      for (int k = 0; k < NDIG; k++) begin
        step(1'b0, nop, 1'b1);
        chk($sformatf("tbl%0d x%0d", v, k), 32'(x_digit), 32'(tbl[v].ex[2*(NDIG-1-k) +: 2]));
        chk($sformatf("tbl%0d d%0d", v, k), 32'(d_digit), 32'(tbl[v].ed[2*(NDIG-1-k) +: 2]));
        chk($sformatf("tbl%0d start%0d", v, k), 32'(op_start), 32'(k == 0));
        chk($sformatf("tbl%0d last%0d", v, k), 32'(op_last), 32'(k == NDIG-1));
      end
    end

    // Full FIFO: third push blocked, one request frees a slot.
    step(1'b1, tbl[0].op, 1'b0);
    step(1'b1, tbl[1].op, 1'b0);
    step(1'b1, tbl[2].op, 1'b0);
    chk("full in_ready", 32'(in_ready), 32'd0);
    chk("full count", 32'(fifo_count), 32'd2);
    step(1'b1, tbl[2].op, 1'b1);
    chk("after pop count", 32'(fifo_count), 32'd1);
    chk("after pop in_ready", 32'(in_ready), 32'd1);
    // Back-to-back drain: no bubble between operations.
    for (int k = 0; k < 2*NDIG - 1; k++) step(1'b0, nop, 1'b1);
    chk("drained busy", 32'(busy), 32'd0);

    // Alternate-cycle requests.
    step(1'b1, tbl[1].op, 1'b0);
    for (int k = 0; k < 2*NDIG; k++) step(1'b0, nop, 1'((k % 2) == 0));

    // Push and request together at empty: stored, underrun flagged.
    step(1'b1, tbl[2].op, 1'b1);
    chk("underrun set", 32'(underrun), 32'd1);
    chk("underrun no valid", 32'(digit_valid), 32'd0);
    for (int k = 0; k < NDIG; k++) step(1'b0, nop, 1'b1);
    step(1'b0, nop, 1'b1);
    step(1'b0, nop, 1'b0);
    chk("underrun sticky", 32'(underrun), 32'd1);

    // Random traffic against the scoreboard.
    for (int k = 0; k < 200; k++) begin
      o = mk(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      o.xm = o.xm & ~o.xp; o.dm = o.dm & ~o.dp;
      step(1'($urandom_range(0, 1)), o, 1'($urandom_range(0, 3) != 0));
    end

    // Reset mid-operation.
    do_reset();
    step(1'b1, tbl[0].op, 1'b0);
    step(1'b1, tbl[1].op, 1'b0);
    step(1'b0, nop, 1'b1);
    step(1'b0, nop, 1'b1);
    reset = 1'b1; digit_req = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; digit_req = 1'b0;
    model_clear();
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst count", 32'(fifo_count), 32'd0);
    chk("midrst digits", 32'({x_digit, d_digit, digit_valid, op_last}), 32'd0);
    step(1'b0, nop, 1'b0);

    // Illegal 11 code handling.
    step(1'b1, mk(4'b1111, 4'b1000, 4'b0100, 4'b0000), 1'b0);
    step(1'b0, nop, 1'b1);
`ifdef ONLINE_SER_DIGIT_CHECK_EN
    chk("illegal first x", 32'(x_digit), 32'd0);
    chk("illegal flag", 32'(illegal_digit), 32'd1);
`else
    chk("verbatim first x", 32'(x_digit), 32'd3);
    chk("illegal tied", 32'(illegal_digit), 32'd0);
`endif
    for (int k = 1; k < NDIG; k++) step(1'b0, nop, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
